muldiv_iter: RTL and testbench
==============================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >=4).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port cancel  input  1  abort current operation (pipeline flush).
REQ-006 SHALL have port op  input  2  00 DIV signed, 01 DIVU, 10 MULT signed, 11 MULTU.
REQ-007 SHALL have port a  input  WIDTH  dividend/multiplicand.
REQ-008 SHALL have port b  input  WIDTH  divisor/multiplier.
REQ-009 SHALL have port busy  output  1  high while in RUN (stall source for hazard logic).
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port hi  output  WIDTH  remainder (div) or upper product half (mul).
REQ-012 SHALL have port lo  output  WIDTH  quotient (div) or lower product half (mul).
REQ-013 SHALL have port dz  output  1  divide-by-zero flag, valid with ready.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE is the reset state.
REQ-015 In IDLE or DONE, start=1 and cancel=0 at an edge SHALL latch op, operand magnitudes and result signs, load counter=WIDTH, enter RUN.
REQ-016 start SHALL be ignored in RUN; a/b/op SHALL be sampled only at acceptance.
REQ-017 RUN SHALL perform one restoring-divide or shift-add-multiply step per edge, decrementing the counter.
REQ-018 On the WIDTH-th RUN edge, hi/lo/dz SHALL be loaded with sign-corrected results and state SHALL enter DONE.
REQ-019 ready SHALL be high exactly one cycle (DONE), i.e. WIDTH+1 edges after the accepting edge; busy SHALL be low in DONE.
REQ-020 DONE without start SHALL return to IDLE next edge; hi/lo/dz SHALL hold until the next result load.
REQ-021 Signed divide: quotient sign = sign(a) xor sign(b); remainder sign = sign(a); most-negative / -1 SHALL give lo=most-negative, hi=0.
REQ-022 b=0 divide SHALL complete with normal latency, dz=1, lo=all ones, hi=a; dz SHALL be 0 for all other operations.
REQ-023 Signed multiply SHALL negate the 2*WIDTH-bit magnitude product when operand signs differ.
REQ-024 cancel=1 in any state SHALL force IDLE next edge, suppress ready, leave hi/lo/dz unchanged.
REQ-025 cancel and start high together SHALL be treated as cancel; start dropped.

Reset
REQ-026 reset SHALL immediately, independent of clk, force IDLE, counter=0, busy=0, ready=0, dz=0, hi=0, lo=0, internal registers 0.
REQ-027 Reset mid-RUN SHALL discard the operation with no ready pulse after release.

Configuration
REQ-028 Macro MULDIV_MUL_EN defined: MULT/MULTU operate per REQ-017..REQ-023.
REQ-029 MULDIV_MUL_EN undefined: multiply datapath omitted; accepted op[1]=1 requests SHALL go directly to DONE (ready next cycle) with hi=lo=0, dz=0; divide unaffected.

Verification (WIDTH=32)
REQ-030 DIVU a=100 b=7 -> ready exactly 33 cycles after accepting edge, lo=14, hi=2, dz=0, busy high 32 cycles.
REQ-031 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 DIVU a=0x1234 b=0 -> dz=1, lo=0xFFFFFFFF, hi=0x00001234, normal latency.
REQ-033 MULT a=0xFFFFFFFD (-3) b=5 with MULDIV_MUL_EN -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without macro -> ready next cycle, hi=lo=0.
REQ-034 cancel at 10th RUN cycle of DIVU -> busy low next cycle, no ready, hi/lo keep previous result; start next cycle accepted normally; start+cancel together in IDLE -> stays IDLE.
REQ-035 reset asserted mid-RUN between edges -> busy/ready/hi/lo/dz zero immediately; no ready after release; back-to-back start in DONE accepted without IDLE gap.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: restoring divide and shift-add multiply, one bit per clock.
// Define MULDIV_MUL_EN to build the multiply datapath; otherwise multiply requests complete at once with zero.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dzp_q, dzp_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
`ifdef MULDIV_MUL_EN
    logic             mul_q, mul_d;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod, prod_fix;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] step_rem, step_quo;

    // op[0]=0 selects the signed variant for both divide and multiply
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Restoring divide: quo_q shifts the dividend out into the partial remainder
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, bmag_q};

`ifdef MULDIV_MUL_EN
    // Shift-add multiply: quo_q holds the multiplier and collects the low product half
    assign msum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, bmag_q} : '0);
    assign step_rem = mul_q ? msum[WIDTH:1] : (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]);
    assign step_quo = mul_q ? {msum[0], quo_q[WIDTH-1:1]} : {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign prod     = {step_rem, step_quo};
    assign prod_fix = neg_q ? -prod : prod;
`else
    assign step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dzp_d   = dzp_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
`ifdef MULDIV_MUL_EN
        mul_d   = mul_q;
`endif
        if (cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
`ifndef MULDIV_MUL_EN
                        if (op[1]) begin
                            state_d = S_DONE;
                            hi_d    = '0;
                            lo_d    = '0;
                            dz_d    = 1'b0;
                        end else
`endif
                        begin
                            state_d = S_RUN;
                            cnt_d   = CW'(WIDTH);
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dzp_d   = ~op[1] & (b == '0);
                            bmag_d  = b_abs;
                            rem_d   = '0;
                            quo_d   = a_abs;
`ifdef MULDIV_MUL_EN
                            mul_d   = op[1];
`endif
                        end
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q - CW'(1);
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        dz_d    = dzp_q;
                        hi_d    = rneg_q ? -step_rem : step_rem;
                        lo_d    = dzp_q ? '1 : (neg_q ? -step_quo : step_quo);
`ifdef MULDIV_MUL_EN
                        if (mul_q) begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            bmag_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
`ifdef MULDIV_MUL_EN
            mul_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dzp_q   <= dzp_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
`ifdef MULDIV_MUL_EN
            mul_q   <= mul_d;
`endif
        end
    end

    assign busy  = (state_q == S_RUN);
    assign ready = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign dz    = dz_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at WIDTH=32; expectations follow MULDIV_MUL_EN.
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, ready, dz;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_MULT = 2'b10, OP_MULTU = 2'b11;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
        .a(a), .b(b), .busy(busy), .ready(ready), .hi(hi), .lo(lo), .dz(dz)
    );

    always #5 clk = ~clk;

    // Issues one request and waits for ready. lat = index of the edge after the
    // accepting edge whose sample sees ready high; bsy = cycles busy was seen high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bsy);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        lat = 1; bsy = 0;
        while (!ready && lat < 60) begin
            if (busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({busy, ready, dz, hi, lo} !== 67'd0) begin n_err++;
            $display("FAIL reset_outputs: got busy=%b ready=%b dz=%b hi=%h lo=%h, want all 0", busy, ready, dz, hi, lo); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({busy, ready} !== 2'b00) begin n_err++;
            $display("FAIL reset_idle: got busy=%b ready=%b, want 0 0", busy, ready); end
    endtask

    task automatic test_divu();
        int lat, bsy;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bsy);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_cmp++; if (bsy !== 32) begin n_err++; $display("FAIL divu_busy_cycles: got %0d want 32", bsy); end
        n_cmp++; if ({hi, lo, dz} !== {32'd2, 32'd14, 1'b0}) begin n_err++;
            $display("FAIL divu_100_7: got hi=%h lo=%h dz=%b want hi=2 lo=e dz=0", hi, lo, dz); end
        @(posedge clk); #1;
        n_cmp++; if ({ready, busy} !== 2'b00 || lo !== 32'd14 || hi !== 32'd2) begin n_err++;
            $display("FAIL divu_hold: got ready=%b busy=%b hi=%h lo=%h want 0 0 2 e", ready, busy, hi, lo); end
    endtask

    task automatic test_div_signed();
        int lat, bsy;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bsy);
        n_cmp++; if ({hi, lo, dz} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin n_err++;
            $display("FAIL div_m7_2: got hi=%h lo=%h dz=%b want ffffffff fffffffd 0", hi, lo, dz); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy);
        n_cmp++; if ({hi, lo, dz} !== {32'h0, 32'h8000_0000, 1'b0}) begin n_err++;
            $display("FAIL div_minneg_m1: got hi=%h lo=%h dz=%b want 0 80000000 0", hi, lo, dz); end
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, lat, bsy);
        n_cmp++; if ({hi, lo} !== {32'd2, 32'hFFFF_FFF2}) begin n_err++;
            $display("FAIL div_100_m7: got hi=%h lo=%h want 2 fffffff2", hi, lo); end
    endtask

    task automatic test_div_zero();
        int lat, bsy;
        run_op(OP_DIVU, 32'h1234, 32'd0, lat, bsy);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divz_latency: got %0d want 33", lat); end
        n_cmp++; if ({hi, lo, dz} !== {32'h1234, 32'hFFFF_FFFF, 1'b1}) begin n_err++;
            $display("FAIL divu_zero: got hi=%h lo=%h dz=%b want 1234 ffffffff 1", hi, lo, dz); end
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, bsy);
        n_cmp++; if ({hi, lo, dz} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin n_err++;
            $display("FAIL div_zero_neg: got hi=%h lo=%h dz=%b want fffffffb ffffffff 1", hi, lo, dz); end
    endtask

    task automatic test_mult();
        int lat, bsy;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bsy);
`ifdef MULDIV_MUL_EN
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency: got %0d want 33", lat); end
        n_cmp++; if ({hi, lo, dz} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}) begin n_err++;
            $display("FAIL mult_m3_5: got hi=%h lo=%h dz=%b want ffffffff fffffff1 0", hi, lo, dz); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy);
        n_cmp++; if ({hi, lo, dz} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin n_err++;
            $display("FAIL multu_max: got hi=%h lo=%h dz=%b want fffffffe 00000001 0", hi, lo, dz); end
`else
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL mult_off_latency: got %0d want 1", lat); end
        n_cmp++; if ({hi, lo, dz} !== 65'd0) begin n_err++;
            $display("FAIL mult_off_result: got hi=%h lo=%h dz=%b want 0 0 0", hi, lo, dz); end
        n_cmp++; if (bsy !== 0) begin n_err++; $display("FAIL mult_off_busy: got %0d want 0", bsy); end
`endif
    endtask

    task automatic test_cancel();
        int lat, bsy, seen;
        run_op(OP_DIVU, 32'd1000, 32'd3, lat, bsy);
        n_cmp++; if ({hi, lo} !== {32'd1, 32'd333}) begin n_err++;
            $display("FAIL divu_1000_3: got hi=%h lo=%h want 1 14d", hi, lo); end
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        n_cmp++; if ({busy, ready} !== 2'b00 || {hi, lo} !== {32'd1, 32'd333}) begin n_err++;
            $display("FAIL cancel_run: got busy=%b ready=%b hi=%h lo=%h want 0 0 1 14d", busy, ready, hi, lo); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready || busy) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL cancel_no_ready: got %0d active cycles want 0", seen); end
        run_op(OP_DIVU, 32'd50, 32'd5, lat, bsy);
        n_cmp++; if (lat !== 33 || {hi, lo} !== {32'd0, 32'd10}) begin n_err++;
            $display("FAIL after_cancel: got lat=%0d hi=%h lo=%h want 33 0 a", lat, hi, lo); end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        seen = 0;
        repeat (3) begin if (ready || busy) seen++; @(posedge clk); #1; end
        n_cmp++; if (seen !== 0 || {hi, lo} !== {32'd0, 32'd10}) begin n_err++;
            $display("FAIL start_cancel_idle: got %0d active hi=%h lo=%h want 0 0 a", seen, hi, lo); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd77; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if ({busy, ready, dz, hi, lo} !== 67'd0) begin n_err++;
            $display("FAIL reset_async: got busy=%b ready=%b dz=%b hi=%h lo=%h want all 0", busy, ready, dz, hi, lo); end
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready || busy) seen++; end
        n_cmp++; if (seen !== 0 || lo !== 32'd0) begin n_err++;
            $display("FAIL reset_discard: got %0d active cycles lo=%h want 0 0", seen, lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bsy;
        run_op(OP_DIVU, 32'd9, 32'd4, lat, bsy);
        n_cmp++; if ({hi, lo} !== {32'd1, 32'd2}) begin n_err++;
            $display("FAIL b2b_first: got hi=%h lo=%h want 1 2", hi, lo); end
        // run_op raises start at the next falling edge, still inside the DONE cycle
        run_op(OP_DIVU, 32'd255, 32'd16, lat, bsy);
        n_cmp++; if (lat !== 33 || bsy !== 32 || {hi, lo} !== {32'd15, 32'd15}) begin n_err++;
            $display("FAIL b2b_second: got lat=%0d busy=%0d hi=%h lo=%h want 33 32 f f", lat, bsy, hi, lo); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_mult();
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_cleared_by_mult: got %b want 0", dz); end
        test_cancel();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
